// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: forwards fetch addresses in normal operation,
// and on request holds the core in reset while a loader streams a program into memory.
module imem_boot_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_RELEASE
    } state_e;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [ADDR_W:0] len_q, len_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            len_ok;
    logic            unused_ok;

    assign len_ok    = (ld_len != '0) && (ld_len <= MAX_LEN);
    assign unused_ok = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_pc[ADDR_W+1:2];
        mem_wdata = ld_data;
        cpu_instr = mem_rdata;
        cpu_stall = 1'b0;
        cpu_rst_n = rst_n;

        unique case (state_q)
            ST_RUN: begin
                if (ld_start) begin
                    if (len_ok) begin
                        len_d   = ld_len;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // ld_ready depends only on state and reset, never on ld_valid.
                ld_ready  = rst_n;
                mem_addr  = cnt_q[ADDR_W-1:0];
                mem_we    = ld_valid & rst_n;
                cpu_rst_n = 1'b0;
                cpu_stall = 1'b1;
                cpu_instr = '0;
                if (ld_valid && ld_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                mem_addr  = '0;
                cpu_rst_n = 1'b0;
                cpu_stall = 1'b1;
                cpu_instr = '0;
                done_d    = 1'b1;
                state_d   = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign busy = (state_q != ST_RUN);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed vector table, hand sequences for
// throttled/illegal/full-depth/abort loads, then random stimulus against a transaction model.
module tb_imem_boot_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n, ld_start, ld_valid, ld_ready;
    logic [AW:0]   ld_len;
    logic [31:0]   ld_data, cpu_pc, cpu_instr, mem_wdata, mem_rdata;
    logic          cpu_stall, cpu_rst_n, mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;

    logic [31:0]   tb_mem  [DEPTH];
    logic [31:0]   ref_mem [DEPTH];

    imem_boot_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_len    (ld_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_pc    (cpu_pc),
        .cpu_instr (cpu_instr),
        .cpu_stall (cpu_stall),
        .cpu_rst_n (cpu_rst_n),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Single-port memory: asynchronous read, write on the rising edge.
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int wr_q[$];

    // Transaction-level model: words still to accept, next write pointer, release pending.
    int m_left = 0;
    int m_wptr = 0;
    bit m_rel  = 0;
    bit m_done = 0;
    bit m_err  = 0;

    typedef struct {
        logic        rst_n;
        logic        ld_start;
        logic [10:0] ld_len;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic [31:0] cpu_pc;
        logic        e_busy;
        logic        e_we;
        logic [9:0]  e_addr;
        logic        e_rstn;
        logic        e_ready;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_model();
        bit          ld     = (m_left > 0);
        bit          busy_e = ld || m_rel;
        bit          we_e   = rst_n && ld && ld_valid;
        logic [9:0]  a_e    = ld ? 10'(m_wptr) : (m_rel ? 10'd0 : cpu_pc[11:2]);
        logic [31:0] i_e    = busy_e ? 32'd0 : ref_mem[cpu_pc[11:2]];
        check("busy", busy, busy_e);
        check("ld_ready", ld_ready, rst_n && ld);
        check("mem_we", mem_we, we_e);
        check("mem_addr", mem_addr, a_e);
        if (we_e) check("mem_wdata", mem_wdata, ld_data);
        check("cpu_instr", cpu_instr, i_e);
        check("cpu_stall", cpu_stall, busy_e);
        check("cpu_rst_n", cpu_rst_n, rst_n && !busy_e);
        check("done", done, m_done);
        check("err", err, m_err);
        if (mem_we === 1'b1) begin
            wr_cnt++;
            wr_q.push_back(int'(mem_addr));
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_left = 0; m_wptr = 0; m_rel = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = m_rel;
            m_err  = 0;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_left > 0) begin
                if (ld_valid) begin
                    ref_mem[m_wptr] = ld_data;
                    m_wptr = (m_wptr + 1) % DEPTH;
                    m_left--;
                    if (m_left == 0) m_rel = 1;
                end
            end else if (ld_start) begin
                if (int'(ld_len) >= 1 && int'(ld_len) <= DEPTH) begin
                    m_left = int'(ld_len);
                    m_wptr = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int d0, e0, w0, zeros, mism;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  <= 32'hC0DE_0000 | i;
            ref_mem[i]  = 32'hC0DE_0000 | i;
        end
        rst_n = 0; ld_start = 0; ld_len = '0; ld_valid = 0; ld_data = '0; cpu_pc = 32'h8;

        //            rst st len valid data        pc    busy we addr rstn rdy done err
        vecs[0]  = '{1'b0, 1'b0, 11'd0, 1'b0, 32'h0,  32'h8, 1'b0, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 11'd0, 1'b0, 32'h0,  32'h8, 1'b0, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 11'd0, 1'b0, 32'h0,  32'h8, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 11'd4, 1'b0, 32'h0,  32'h8, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 11'd0, 1'b1, 32'hA0, 32'h8, 1'b1, 1'b1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 11'd0, 1'b1, 32'hA1, 32'h8, 1'b1, 1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 11'd0, 1'b1, 32'hA2, 32'h8, 1'b1, 1'b1, 10'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 11'd0, 1'b1, 32'hA3, 32'h8, 1'b1, 1'b1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 11'd0, 1'b0, 32'h0,  32'h8, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 11'd0, 1'b0, 32'h0,  32'h8, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 11'd0, 1'b0, 32'h0,  32'h8, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};

        @(posedge clk);
        model_update();
        #1;

        // Reset, RUN fetch and a back-to-back 4-word load.
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; ld_start = vecs[i].ld_start; ld_len = vecs[i].ld_len;
            ld_valid = vecs[i].ld_valid; ld_data = vecs[i].ld_data; cpu_pc = vecs[i].cpu_pc;
            @(negedge clk);
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
            check($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_rstn", i), cpu_rst_n, vecs[i].e_rstn);
            check($sformatf("v%0d_ready", i), ld_ready, vecs[i].e_ready);
            check($sformatf("v%0d_done", i), done, vecs[i].e_done);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            compare_model();
            @(posedge clk);
            model_update();
            #1;
        end
        for (int i = 0; i < 4; i++) check($sformatf("b2b_word%0d", i), tb_mem[i], 32'hA0 + i);

        // Throttled 3-word load.
        wr_q.delete();
        ld_start = 1; ld_len = 11'd3;
        step();
        ld_start = 0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = $urandom;
            step();
        end
        ld_valid = 0;
        step();
        step();
        check("thr_writes", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) check("thr_addr", wr_q[i], i);

        // Illegal lengths.
        e0 = err_cnt; w0 = wr_cnt;
        ld_start = 1; ld_len = 11'd0;
        step();
        ld_start = 0;
        step();
        ld_start = 1; ld_len = 11'd1025;
        step();
        ld_start = 0;
        step();
        check("ill_err_pulses", err_cnt - e0, 2);
        check("ill_no_write", wr_cnt - w0, 0);
        check("ill_busy", busy, 0);

        // Full-depth load.
        wr_q.delete(); d0 = done_cnt;
        ld_start = 1; ld_len = 11'd1024;
        step();
        ld_start = 0; ld_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_data = $urandom;
            step();
        end
        ld_valid = 0;
        step();
        check("full_no_early_done", done_cnt - d0, 0);
        step();
        check("full_done", done_cnt - d0, 1);
        check("full_writes", wr_q.size(), 1024);
        if (wr_q.size() > 0) check("full_last_addr", wr_q[wr_q.size()-1], 1023);
        zeros = 0;
        foreach (wr_q[i]) if (wr_q[i] == 0) zeros++;
        check("full_addr0_once", zeros, 1);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        check("full_mem_image", mism, 0);

        // Abort by reset after 2 of 5 words, then a fresh 1-word load.
        d0 = done_cnt;
        ld_start = 1; ld_len = 11'd5;
        step();
        ld_start = 0; ld_valid = 1;
        ld_data = $urandom; step();
        ld_data = $urandom; step();
        rst_n = 0; ld_data = $urandom;
        step();
        rst_n = 1; ld_valid = 0;
        step();
        step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_busy", busy, 0);
        ld_start = 1; ld_len = 11'd1;
        step();
        ld_start = 0; ld_valid = 1; ld_data = $urandom;
        step();
        ld_valid = 0;
        step();
        step();
        check("abort_reload_done", done_cnt - d0, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst_n    = ($urandom_range(0, 49) != 0);
            ld_start = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      ld_len = 11'd0;
            else if (r == 1) ld_len = 11'(1025 + $urandom_range(0, 1022));
            else             ld_len = 11'($urandom_range(1, 8));
            ld_valid = ($urandom_range(0, 9) < 7);
            ld_data  = $urandom;
            cpu_pc   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Sequencer that owns the write/address side of the single-port, asynchronous-read instruction memory of the pipelined MIPS core. In normal operation it forwards the fetch stage's PC to the memory. On request it holds the core in reset, streams a program from an external loader into the memory over a valid/ready handshake, and then releases the core to fetch from address 0. It sits between the fetch stage, the instruction memory and the program loader (UART/debug).

## Interface
- ADDR_W, 10, word-address width of the instruction memory (2^ADDR_W words, default 1024).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ld_start  in  1  load request; honoured only in RUN.
- ld_len  in  ADDR_W+1  number of words to load; sampled with ld_start; legal range 1..2^ADDR_W.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_ready  out  1  controller accepts ld_data this cycle.
- cpu_pc  in  32  byte address from the fetch stage.
- cpu_instr  out  32  instruction to the fetch stage.
- cpu_stall  out  1  fetch/pipeline hold.
- cpu_rst_n  out  1  active-low reset to the core.
- mem_addr  out  ADDR_W  word address to the instruction memory.
- mem_we  out  1  memory write enable (written on the rising edge).
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data (combinational from mem_addr).
- busy  out  1  high in LOAD or RELEASE.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse when ld_start carries an illegal ld_len.

## Operation
- States: RUN, LOAD, RELEASE. Registers: state, cnt (ADDR_W+1 bits), len (ADDR_W+1 bits), err, done.
- RUN:
  - mem_addr = cpu_pc[ADDR_W+1:2]; cpu_instr = mem_rdata; mem_we = 0; ld_ready = 0; cpu_stall = 0; cpu_rst_n = 1.
  - ld_start with 1 <= ld_len <= 2^ADDR_W: len <= ld_len, cnt <= 0, go to LOAD.
  - ld_start with an illegal ld_len (0 or > 2^ADDR_W): err pulses next cycle, stay in RUN.
- LOAD:
  - ld_ready = 1; mem_addr = cnt[ADDR_W-1:0]; mem_wdata = ld_data; mem_we = ld_valid.
  - cpu_rst_n = 0; cpu_stall = 1; cpu_instr = 32'h0000_0000 (NOP).
  - Accept (ld_valid & ld_ready): cnt <= cnt+1. If the accept occurs when cnt == len-1, go to RELEASE.
  - ld_start is ignored. ld_valid low inserts wait cycles indefinitely, with no write.
- RELEASE (exactly one cycle):
  - ld_ready = 0; mem_we = 0; mem_addr = 0; cpu_rst_n = 0; cpu_stall = 1; cpu_instr = 0.
  - done <= 1, so done is high in the first RUN cycle. Go to RUN.
- cpu_pc bits above ADDR_W+1 and bits [1:0] are ignored. Addresses wrap modulo 2^ADDR_W words.
- A full-depth load (len = 2^ADDR_W) writes word addresses 0..2^ADDR_W-1. cnt is one bit wider than the address, so the completion compare does not alias.

## Timing
- Reset (rst_n low at a clock edge): state = RUN, cnt = 0, len = 0, done = 0, err = 0.
- While rst_n is low: cpu_rst_n = 0 and mem_we = 0 (combinationally gated). ld_ready = 0.
- Reset during LOAD aborts the load. Words already written remain in memory, and the next cycle is RUN with no done pulse.
- RUN -> LOAD latency: 1 cycle after ld_start. The first write can occur in the first LOAD cycle.
- Throughput: one word per cycle while ld_valid is held high. An N-word load with no bubbles occupies N LOAD cycles, then 1 RELEASE cycle. The core leaves reset on the cycle N+2 after ld_start.
- All outputs are combinational decodes of registered state/cnt and inputs. There are no combinational paths from ld_valid to ld_ready.
- ld_start asserted in the same cycle as reset: reset wins.

## Test plan
- Reset then RUN fetch: rst_n low for 2 cycles, then cpu_pc = 0x0000_0008 -> mem_addr = 2, mem_we = 0, cpu_instr = mem_rdata, cpu_rst_n = 1, busy = 0.
- Back-to-back load: ld_start with ld_len = 4, then ld_valid high with data 0xA0..0xA3 -> mem_we high for 4 cycles at addresses 0..3, one RELEASE cycle, done high 6 cycles after ld_start, cpu_rst_n high from that cycle.
- Throttled load: ld_len = 3 with ld_valid toggling 1,0,1,0,1 -> exactly 3 writes at addresses 0,1,2. Nothing is written on idle cycles, and cpu_stall stays high until RUN.
- Illegal length: ld_start with ld_len = 0, then ld_len = 1025 (ADDR_W = 10) -> err pulses once per request, state stays RUN, and no memory write occurs.
- Full depth: ld_len = 1024 -> last write at address 1023, no write to address 0 after wrap, done after 1024 accepts.
- Abort: reset asserted after 2 of 5 words -> mem_we = 0 during reset, no done pulse, RUN afterwards. A fresh ld_start (ld_len = 1) is accepted normally.
